// File: rtl/picobus128_initiator.sv
// picobus128_initiator: single-outstanding 128-bit PicoBus master with valid/ready client request/response channels
module picobus128_initiator #(
   parameter int RD_LAT = 1,
   parameter int CNT_W = 32
) (
   input  logic PicoClk,
   input  logic PicoRst_n,
   output logic [31:0] PicoAddr,
   output logic [127:0] PicoDataOut,
   output logic PicoRd,
   output logic PicoWr,
   input  logic [127:0] PicoDataIn,
   input  logic req_valid,
   output logic req_ready,
   input  logic req_write,
   input  logic [31:0] req_addr,
   input  logic [127:0] req_wdata,
   output logic rsp_valid,
   input  logic rsp_ready,
   output logic [127:0] rsp_data,
   output logic busy,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic [3:0] lat;
   logic accept, last_wait;
   assign accept = state == IDLE && req_valid && req_ready;
   assign last_wait = state == WAIT && lat == 4'd1;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? ISSUE : IDLE;
         ISSUE:   state_nxt = PicoWr ? IDLE : WAIT;
         WAIT:    state_nxt = last_wait ? RESP : WAIT;
         RESP:    state_nxt = rsp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end
   // Bus strobes, address and write data are loaded on acceptance so they appear only in ISSUE.
   always_ff @(posedge PicoClk or negedge PicoRst_n) begin
      if (!PicoRst_n) begin
         state <= IDLE;
         PicoAddr <= '0;
         PicoDataOut <= '0;
         PicoRd <= 1'b0;
         PicoWr <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         busy <= 1'b0;
         lat <= '0;
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         state <= state_nxt;
         PicoAddr <= accept ? req_addr : '0;
         PicoDataOut <= accept && req_write ? req_wdata : '0;
         PicoRd <= accept && !req_write;
         PicoWr <= accept && req_write;
         req_ready <= state_nxt == IDLE;
         rsp_valid <= state_nxt == RESP;
         busy <= state_nxt != IDLE;
         lat <= state == ISSUE ? 4'(RD_LAT) : state == WAIT ? lat - 4'd1 : lat;
         if (last_wait) rsp_data <= PicoDataIn;
         if (state == ISSUE && PicoWr) wr_count <= wr_count + CNT_W'(1);
         if (state == RESP && rsp_ready) rd_count <= rd_count + CNT_W'(1);
      end
   end
endmodule
